// File: rtl/pc_sequencer_if.sv
// Signal bundle between the fetch-stage controller and pc_sequencer.
// Carries branch/jump controls in and PC, link value and RAS status out.
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  // No valid/ready pair: every control input is sampled on each rising
  // edge and Stall is the only way to hold. Exception overrides Stall.
  logic [WIDTH-1:0] startPC;
  logic             Stall;
  logic             Branch;
  logic             BranchNE;
  logic             ALUZero;
  logic             Jump;
  logic [25:0]      JumpField;
  logic             JumpReg;
  logic [WIDTH-1:0] RegTarget;
  logic             Link;
  logic             Return;
  logic [WIDTH-1:0] SignExtImm;
  logic             Exception;

  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] NextPC;
  logic [WIDTH-1:0] PCPlus4;
  logic [WIDTH-1:0] EPC;
  logic             RASEmpty;
  logic             RASFull;
  logic             RASMiss;
  logic             RASUnderflow;
  logic [CW-1:0]    rasCount;   // debug: live RAS occupancy

  modport master (
    output startPC, Stall, Branch, BranchNE, ALUZero, Jump, JumpField,
           JumpReg, RegTarget, Link, Return, SignExtImm, Exception,
    input  PC, NextPC, PCPlus4, EPC, RASEmpty, RASFull, RASMiss,
           RASUnderflow, rasCount
  );

  modport slave (
    input  startPC, Stall, Branch, BranchNE, ALUZero, Jump, JumpField,
           JumpReg, RegTarget, Link, Return, SignExtImm, Exception,
    output PC, NextPC, PCPlus4, EPC, RASEmpty, RASFull, RASMiss,
           RASUnderflow, rasCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/jr/exception redirect, EPC
// capture and a circular return-address stack that checks jr $ra targets.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h00000180)
) (
  input logic           CLK,
  input logic           Reset_L,
  pc_sequencer_if.slave bus
);
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam int            CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CountMax = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pcQ;
  logic [WIDTH-1:0] epcQ;
  logic [WIDTH-1:0] rasMem [RAS_DEPTH];
  logic [PW-1:0]    topQ;
  logic [CW-1:0]    countQ;
  logic             missQ;
  logic             underflowQ;

  logic [WIDTH-1:0] pcPlus4;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] jumpTarget;
  logic [WIDTH-1:0] nextPc;
  logic             taken;

  logic             rasUpdate;
  logic             wantPush;
  logic             wantPop;
  logic             rasNonEmpty;
  logic [WIDTH-1:0] rasTopEntry;

  logic [PW-1:0]    topD;
  logic [CW-1:0]    countD;
  logic             writeEn;
  logic [PW-1:0]    writeIdx;
  logic             missD;
  logic             underflowD;

  // ---------------- next-PC datapath ----------------
  always_comb begin
    pcPlus4      = pcQ + WIDTH'(4);
    branchTarget = pcPlus4 + (bus.SignExtImm << 2);
    jumpTarget   = {pcPlus4[WIDTH-1:28], bus.JumpField, 2'b00};
    taken        = bus.Branch & (bus.ALUZero ^ bus.BranchNE);

    nextPc = pcPlus4;
    if (bus.Exception)    nextPc = EXC_VECTOR;
    else if (bus.JumpReg) nextPc = bus.RegTarget;
    else if (bus.Jump)    nextPc = jumpTarget;
    else if (taken)       nextPc = branchTarget;
  end

  // ---------------- return-address stack control ----------------
  // Stall and Exception freeze the stack and squash the status pulses.
  always_comb begin
    rasUpdate   = ~bus.Exception & ~bus.Stall;
    wantPush    = bus.Link & (bus.Jump | bus.JumpReg);
    wantPop     = bus.JumpReg & bus.Return;
    rasNonEmpty = (countQ != '0);
    rasTopEntry = rasMem[topQ];

    topD       = topQ;
    countD     = countQ;
    writeEn    = 1'b0;
    writeIdx   = topQ;
    missD      = 1'b0;
    underflowD = 1'b0;

    if (rasUpdate) begin
      if (wantPop && bus.Link) begin
        // jalr $ra,$ra: replace the top in place; an empty stack gains one.
        writeEn  = 1'b1;
        writeIdx = topQ;
        if (rasNonEmpty) missD  = (rasTopEntry != bus.RegTarget);
        else             countD = CW'(1);
      end else if (wantPop) begin
        if (rasNonEmpty) begin
          missD  = (rasTopEntry != bus.RegTarget);
          topD   = topQ - PW'(1);
          countD = countQ - CW'(1);
        end else begin
          underflowD = 1'b1;
        end
      end else if (wantPush) begin
        // Pointer wraps, so a push on a full stack lands on the oldest entry.
        writeEn  = 1'b1;
        writeIdx = topQ + PW'(1);
        topD     = topQ + PW'(1);
        if (countQ != CountMax) countD = countQ + CW'(1);
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pcQ  <= bus.startPC;
      epcQ <= '0;
    end else if (bus.Exception) begin
      pcQ  <= EXC_VECTOR;
      epcQ <= pcQ;
    end else if (!bus.Stall) begin
      pcQ  <= nextPc;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      topQ       <= '0;
      countQ     <= '0;
      missQ      <= 1'b0;
      underflowQ <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) rasMem[i] <= '0;
    end else begin
      topQ       <= topD;
      countQ     <= countD;
      missQ      <= missD;
      underflowQ <= underflowD;
      if (writeEn) rasMem[writeIdx] <= pcPlus4;
    end
  end

  // ---------------- outputs ----------------
  assign bus.PC           = pcQ;
  assign bus.NextPC       = nextPc;
  assign bus.PCPlus4      = pcPlus4;
  assign bus.EPC          = epcQ;
  assign bus.RASEmpty     = (countQ == '0);
  assign bus.RASFull      = (countQ == CountMax);
  assign bus.RASMiss      = missQ;
  assign bus.RASUnderflow = underflowQ;
  assign bus.rasCount     = countQ;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus
// random control traffic, all compared every cycle against a queue-based model.
module tb_pc_sequencer;
  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h00000180;

  logic CLK;
  logic Reset_L;

  pc_sequencer_if #(.WIDTH(W), .RAS_DEPTH(DEPTH)) bus ();

  pc_sequencer #(.WIDTH(W), .RAS_DEPTH(DEPTH), .EXC_VECTOR(EXC)) dut (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // behavioural model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_epc;
  logic [W-1:0] ras_q[$];
  logic         m_miss;
  logic         m_under;
  logic [W-1:0] exp_q[$];

  // ---------------- clock ----------------
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] pc);
    logic [W-1:0] pc4;
    pc4 = pc + 4;
    if (bus.Exception) return EXC;
    if (bus.JumpReg)   return bus.RegTarget;
    if (bus.Jump)      return {pc4[31:28], bus.JumpField, 2'b00};
    if (bus.Branch && (bus.ALUZero != bus.BranchNE)) return pc4 + (bus.SignExtImm << 2);
    return pc4;
  endfunction

  // ---------------- reference model ----------------
  initial begin
    forever begin
      @(posedge CLK or negedge Reset_L);
      if (!Reset_L) begin
        m_pc    = bus.startPC;
        m_epc   = '0;
        m_miss  = 0;
        m_under = 0;
        ras_q.delete();
      end else begin
        logic [W-1:0] pc4;
        logic [W-1:0] nxt;
        logic [W-1:0] popped;
        pc4     = m_pc + 4;
        nxt     = model_next(m_pc);
        m_miss  = 0;
        m_under = 0;
        if (bus.Exception) begin
          m_epc = m_pc;
          m_pc  = EXC;
        end else if (!bus.Stall) begin
          if (bus.JumpReg && bus.Return && bus.Link) begin
            if (ras_q.size() == 0) ras_q.push_back(pc4);
            else begin
              m_miss = (ras_q[ras_q.size()-1] != bus.RegTarget);
              ras_q[ras_q.size()-1] = pc4;
            end
          end else if (bus.JumpReg && bus.Return) begin
            if (ras_q.size() == 0) m_under = 1;
            else begin
              popped = ras_q.pop_back();
              m_miss = (popped != bus.RegTarget);
            end
          end else if (bus.Link && (bus.Jump || bus.JumpReg)) begin
            ras_q.push_back(pc4);
            if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
          end
          m_pc = nxt;
        end
      end
      exp_q.delete();
      exp_q.push_back(m_pc);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pc_expect: no expected PC queued at %0t", $time);
        end else begin
          check("PC", bus.PC, exp_q.pop_front());
          exp_q.push_back(m_pc);
        end
        check("NextPC", bus.NextPC, model_next(m_pc));
        check("PCPlus4", bus.PCPlus4, m_pc + 4);
        check("EPC", bus.EPC, m_epc);
        check("RASEmpty", W'(bus.RASEmpty), W'(ras_q.size() == 0));
        check("RASFull", W'(bus.RASFull), W'(ras_q.size() == DEPTH));
        check("RASMiss", W'(bus.RASMiss), W'(m_miss));
        check("RASUnderflow", W'(bus.RASUnderflow), W'(m_under));
        check("rasCount", W'(bus.rasCount), W'(ras_q.size()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.Stall      = 0;
    bus.Branch     = 0;
    bus.BranchNE   = 0;
    bus.ALUZero    = 0;
    bus.Jump       = 0;
    bus.JumpField  = '0;
    bus.JumpReg    = 0;
    bus.RegTarget  = '0;
    bus.Link       = 0;
    bus.Return     = 0;
    bus.SignExtImm = '0;
    bus.Exception  = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset(input logic [W-1:0] start);
    idle();
    bus.startPC = start;
    Reset_L = 0;
    tick();
    Reset_L = 1;
  endtask

  task automatic jal_to(input logic [W-1:0] target);
    idle();
    bus.Jump      = 1;
    bus.Link      = 1;
    bus.JumpField = target[27:2];
  endtask

  task automatic jr_ret(input logic [W-1:0] target);
    idle();
    bus.JumpReg   = 1;
    bus.Return    = 1;
    bus.RegTarget = target;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    bus.startPC = 32'h00400000;
    Reset_L = 0;
    #1;

    // Sequential advance from reset
    do_reset(32'h00400000);
    chk_en = 1;
    check("rst_pc", bus.PC, 32'h00400000);
    check("rst_epc", bus.EPC, 32'h0);
    check("rst_empty", W'(bus.RASEmpty), 1);
    check("rst_full", W'(bus.RASFull), 0);
    check("rst_miss", W'(bus.RASMiss), 0);
    check("rst_under", W'(bus.RASUnderflow), 0);
    tick(); check("seq1", bus.PC, 32'h00400004);
    tick(); check("seq2", bus.PC, 32'h00400008);
    tick(); check("seq3", bus.PC, 32'h0040000C);

    // Branches from 0x10
    do_reset(32'h00000010);
    bus.Branch = 1; bus.ALUZero = 1; bus.SignExtImm = 32'hFFFFFFFF;
    #1 check("beq_back_next", bus.NextPC, 32'h00000010);
    tick(); check("beq_back_pc", bus.PC, 32'h00000010);
    bus.SignExtImm = 32'h1;
    tick(); check("beq_fwd_pc", bus.PC, 32'h00000018);
    bus.BranchNE = 1;
    tick(); check("bne_nt_pc", bus.PC, 32'h0000001C);
    idle();

    // Jump across a 256MB region, first stalled
    do_reset(32'h8FFFFFFC);
    bus.Jump = 1; bus.JumpField = 26'h0000100; bus.Stall = 1;
    #1 check("jump_next", bus.NextPC, 32'h90000400);
    tick(); check("jump_stall_pc", bus.PC, 32'h8FFFFFFC);
    bus.Stall = 0;
    tick(); check("jump_pc", bus.PC, 32'h90000400);
    idle();

    // RAS: five pushes overflow a depth-4 stack, then drain it
    do_reset(32'h00000100);
    for (int i = 2; i <= 6; i++) begin
      jal_to(W'(i) << 8);
      tick();
    end
    check("ras_full", W'(bus.RASFull), 1);
    check("ras_pc_after_jal", bus.PC, 32'h00000600);
    for (int i = 5; i >= 2; i--) begin
      jr_ret((W'(i) << 8) + 4);
      tick();
      check("ras_hit_miss", W'(bus.RASMiss), 0);
      check("ras_hit_pc", bus.PC, (W'(i) << 8) + 4);
    end
    check("ras_drained", W'(bus.RASEmpty), 1);
    jr_ret(32'h00000104);
    tick();
    check("ras_underflow", W'(bus.RASUnderflow), 1);
    check("ras_empty_after", W'(bus.RASEmpty), 1);
    idle();
    tick();
    check("ras_underflow_pulse", W'(bus.RASUnderflow), 0);

    // Mispredicted return
    do_reset(32'h00000100);
    jal_to(32'h00000300);
    tick();
    jr_ret(32'h00000200);
    tick();
    check("miss_pc", bus.PC, 32'h00000200);
    check("miss_flag", W'(bus.RASMiss), 1);
    idle();
    tick();
    check("miss_pulse", W'(bus.RASMiss), 0);

    // Exception beats Stall; asynchronous reset mid-cycle
    do_reset(32'h00001234);
    bus.Exception = 1; bus.Stall = 1;
    tick();
    check("exc_pc", bus.PC, 32'h00000180);
    check("exc_epc", bus.EPC, 32'h00001234);
    idle();
    bus.startPC = 32'h00400000;
    #2 Reset_L = 0;
    #1 check("async_rst_pc", bus.PC, 32'h00400000);
    check("async_rst_epc", bus.EPC, 32'h0);
    tick();
    Reset_L = 1;

    // Random traffic against the model
    do_reset($urandom & 32'hFFFFFFFC);
    for (int n = 0; n < 3000; n++) begin
      idle();
      bus.Exception  = ($urandom_range(0, 31) == 0);
      bus.Stall      = ($urandom_range(0, 7) == 0);
      bus.Branch     = $urandom_range(0, 1);
      bus.BranchNE   = $urandom_range(0, 1);
      bus.ALUZero    = $urandom_range(0, 1);
      bus.Jump       = ($urandom_range(0, 3) == 0);
      bus.JumpField  = 26'($urandom);
      bus.JumpReg    = ($urandom_range(0, 3) == 0);
      bus.Link       = ($urandom_range(0, 2) == 0);
      bus.Return     = $urandom_range(0, 1);
      bus.SignExtImm = W'($signed(16'($urandom)));
      if (ras_q.size() > 0 && $urandom_range(0, 1) == 1)
        bus.RegTarget = ras_q[ras_q.size()-1];
      else
        bus.RegTarget = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 499) == 0) begin
        bus.startPC = $urandom & 32'hFFFFFFFC;
        Reset_L = 0;
        tick();
        Reset_L = 1;
      end else begin
        tick();
      end
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit. It is the sequential successor to the combinational next-PC logic.
- Holds PC and computes next PC for sequential advance, branch (beq/bne), jump, jump-register and exception.
- Adds stall, an exception PC (EPC) capture, and a parametrised return-address stack (RAS) that checks jr-return targets.
- Sits at the fetch stage, feeding instruction-memory address and the PC+4 link value.

Parameters:
- WIDTH, 32, PC/address width. Must be >= 29; jump targets replace bits [27:0].
- RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.
- EXC_VECTOR, 32'h00000180, exception handler address (low WIDTH bits used).

Ports:
- CLK  input  1  clock, rising edge
- Reset_L  input  1  asynchronous active-low reset
- startPC  input  WIDTH  PC value loaded during reset
- Stall  input  1  hold PC and RAS this cycle
- Branch  input  1  conditional branch instruction
- BranchNE  input  1  1 = bne sense, 0 = beq sense
- ALUZero  input  1  ALU zero flag
- Jump  input  1  J-type jump
- JumpField  input  26  J-type target field
- JumpReg  input  1  jr/jalr
- RegTarget  input  WIDTH  register-file target for jr
- Link  input  1  jal/jalr; push PCPlus4 on RAS
- Return  input  1  with JumpReg: jr $ra; pop RAS
- SignExtImm  input  WIDTH  sign-extended branch offset (words)
- Exception  input  1  redirect to EXC_VECTOR
- PC  output  WIDTH  current PC (register)
- NextPC  output  WIDTH  combinational next PC
- PCPlus4  output  WIDTH  PC+4 (link value)
- EPC  output  WIDTH  PC of last excepting instruction
- RASEmpty  output  1  RAS count == 0
- RASFull  output  1  RAS count == RAS_DEPTH
- RASMiss  output  1  one-cycle pulse: popped prediction != RegTarget
- RASUnderflow  output  1  one-cycle pulse: pop on empty

Behaviour:
- Reset (Reset_L=0, asynchronous):
  - PC=startPC, EPC=0, RAS count=0, all RAS entries 0.
  - RASMiss=0, RASUnderflow=0; RASEmpty=1, RASFull=0.
- Arithmetic: all adds are modulo 2^WIDTH.
  - PCPlus4 = PC+4.
  - Branch target = PCPlus4 + (SignExtImm<<2).
  - Jump target = {PCPlus4[WIDTH-1:28], JumpField, 2'b00}.
- Taken = Branch & (ALUZero ^ BranchNE).
- NextPC priority: Exception -> EXC_VECTOR; else JumpReg -> RegTarget; else Jump -> jump target; else Taken -> branch target; else PCPlus4.
- Rising CLK:
  - Exception=1: PC<=EXC_VECTOR and EPC<=PC. Exception overrides Stall. RAS unchanged.
  - Otherwise, if Stall=0: PC<=NextPC.
  - If Stall=1 and Exception=0: PC, EPC and RAS hold; pulses deassert.
- RAS is a circular stack with a top pointer and a count. It updates only on non-stalled, non-exception cycles.
  - Push when Link & (Jump|JumpReg): entry[top+1]<=PCPlus4, top++.
    - Count increments, saturating at RAS_DEPTH.
    - Push when full overwrites the oldest entry.
  - Pop when JumpReg & Return & ~Link:
    - If count>0: compare entry[top] with RegTarget; top--, count--. RASMiss<=(entry[top]!=RegTarget) next cycle.
    - If count==0: no change; RASUnderflow<=1 next cycle.
  - JumpReg & Return & Link (jalr $ra,$ra): pop and push in the same cycle. Net effect: entry[top]<=PCPlus4, count unchanged (count 0 -> 1). Compare still performed if count>0.
- RASMiss and RASUnderflow are registered and high for exactly one cycle.
- PC is always RegTarget on jr; the RAS never alters control flow.
- Latency: PC updates on the edge after the inputs are sampled. NextPC, PCPlus4 and the flags are combinational from state.

Test Plan:
1. Reset with startPC=0x00400000; release; 3 clocks, no control -> PC goes 0x00400004, 0x00400008, 0x0040000C.
2. PC=0x00000010:
   - Branch=1, ALUZero=1, SignExtImm=0xFFFFFFFF -> NextPC=0x10, PC=0x10 after edge.
   - Branch=1, BranchNE=1, ALUZero=1 -> not taken, PC=0x14.
   - SignExtImm=1, taken -> PC=0x18.
3. PC=0x8FFFFFFC, Jump=1, JumpField=0x0000100 -> PC=0x90000400. Same with Stall=1 -> PC holds 0x8FFFFFFC.
4. RAS_DEPTH=4:
   - jal at PC=0x100, 0x200, 0x300, 0x400, 0x500 (5 pushes) -> RASFull=1.
   - 4 jr-returns with RegTarget 0x504, 0x404, 0x304, 0x204 -> RASMiss=0 each.
   - 5th pop -> RASUnderflow pulse, RASEmpty=1.
5. Push from PC=0x100 (entry 0x104), then jr-return with RegTarget=0x200 -> PC=0x200 and RASMiss=1 for exactly one cycle.
6. Exception=1 with Stall=1 at PC=0x1234 -> PC=0x180, EPC=0x1234. Assert Reset_L=0 mid-cycle -> PC=startPC immediately, no clock edge required.
